// File: rtl/leglite_io_pkg.sv
// Shared constants for the LEGLite memory-mapped I/O port: data width,
// register byte offsets inside the 8-byte window and TSTAT bit positions.
package leglite_io_pkg;

   localparam int DATA_W = 16;
   typedef logic [DATA_W-1:0] data_t;

   localparam logic [2:0] OFS_SW    = 3'd0;
   localparam logic [2:0] OFS_EDGE  = 3'd2;
   localparam logic [2:0] OFS_TLOAD = 3'd4;
   localparam logic [2:0] OFS_TSTAT = 3'd6;

   localparam int TSTAT_RUN = 0;
   localparam int TSTAT_EXP = 1;

   // Byte offset of a halfword register from address bits [2:1].
   function automatic logic [2:0] ofs_of(input logic [1:0] word_sel);
      return {word_sel, 1'b0};
   endfunction

endpackage

// File: rtl/leglite_io_port_if.sv
// CPU data-bus signals seen by the I/O port. The CPU (master) drives address,
// store data and strobes; the port (slave) returns combinational load data and hit.
interface leglite_io_port_if;
   import leglite_io_pkg::*;

   data_t draddr;
   data_t dwdata;
   logic  dwrite;
   logic  dread;
   data_t drdata;
   logic  hit;

   modport master (output draddr, output dwdata, output dwrite, output dread,
                   input drdata, input hit);
   modport slave  (input draddr, input dwdata, input dwrite, input dread,
                   output drdata, output hit);
endinterface

// File: rtl/leglite_io_port_sw_debounce.sv
// Switch debouncer: two-flop synchronizer followed by a counter that must see
// DEB_CYCLES consecutive differing samples before the stable value follows.
module sw_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic rise
);

   localparam int CW = $clog2(DEB_CYCLES);

   if (DEB_CYCLES < 2) begin : g_bad_deb
      $error("sw_debounce: DEB_CYCLES must be at least 2");
   end

   logic          sync1_q;
   logic          s2_q;
   logic          stable_q;
   logic [CW-1:0] cnt_q;
   logic          settle;

   // settle marks the edge on which stable takes the synchronized value.
   assign settle = (s2_q != stable_q) && (cnt_q == CW'(DEB_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         s2_q     <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q <= raw;
         s2_q    <= sync1_q;
         if (s2_q == stable_q) begin
            cnt_q <= '0;
         end else if (settle) begin
            stable_q <= s2_q;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign stable = stable_q;
   assign rise   = settle & s2_q;

endmodule

// File: rtl/leglite_io_port.sv
// Memory-mapped I/O responder: debounced switches, W1C edge flags and an
// optional countdown timer enabled by the LEGLITE_IO_TIMER_EN macro.
module leglite_io_port
   import leglite_io_pkg::*;
#(
   parameter logic [15:0] BASE       = 16'hFFF0,
   parameter int          DEB_CYCLES = 4,
   parameter int          PRESCALE   = 1
) (
   input  logic               clock,
   input  logic               reset,
   leglite_io_port_if.slave   bus,
   input  logic               io_sw0,
   input  logic               io_sw1
);

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("leglite_io_port: PRESCALE must be at least 1");
   end

   logic       hit;
   logic [2:0] ofs;
   logic       wr_hit;
   logic       wr_edge;
   logic [1:0] sw_stable;
   logic [1:0] sw_rise;
   logic [1:0] edge_flags_d;
   logic [1:0] edge_flags_q;
   data_t      rdata;
   data_t      tload_rd;
   data_t      tstat_rd;
   logic       unused_bits;

   assign hit     = (bus.draddr[15:3] == BASE[15:3]);
   assign ofs     = ofs_of(bus.draddr[2:1]);
   assign wr_hit  = bus.dwrite && hit;
   assign wr_edge = wr_hit && (ofs == OFS_EDGE);

   // Byte-lane bit and upper store-data bits are not part of every build.
   assign unused_bits = ^{bus.draddr[0], bus.dwdata};

   sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sw0 (
      .clock  (clock),
      .reset  (reset),
      .raw    (io_sw0),
      .stable (sw_stable[0]),
      .rise   (sw_rise[0])
   );

   sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sw1 (
      .clock  (clock),
      .reset  (reset),
      .raw    (io_sw1),
      .stable (sw_stable[1]),
      .rise   (sw_rise[1])
   );

   // Set is applied after clear so a same-edge rise survives a W1C store.
   always_comb begin
      edge_flags_d = edge_flags_q;
      if (wr_edge) begin
         edge_flags_d = edge_flags_d & ~bus.dwdata[1:0];
      end
      edge_flags_d = edge_flags_d | sw_rise;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         edge_flags_q <= '0;
      end else begin
         edge_flags_q <= edge_flags_d;
      end
   end

`ifdef LEGLITE_IO_TIMER_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic          wr_tload;
   logic          wr_tstat;
   data_t         count_d, count_q;
   logic [PW-1:0] presc_d, presc_q;
   logic          run_d, run_q;
   logic          exp_d, exp_q;

   assign wr_tload = wr_hit && (ofs == OFS_TLOAD);
   assign wr_tstat = wr_hit && (ofs == OFS_TSTAT);

   // Priority, lowest first: W1C clear, countdown/expiry, then a TLOAD store.
   always_comb begin
      count_d = count_q;
      presc_d = presc_q;
      run_d   = run_q;
      exp_d   = exp_q;
      if (wr_tstat && bus.dwdata[TSTAT_EXP]) begin
         exp_d = 1'b0;
      end
      if (run_q) begin
         if (presc_q == PW'(PRESCALE - 1)) begin
            presc_d = '0;
            if (count_q != '0) begin
               count_d = count_q - data_t'(1);
            end
            if (count_q <= data_t'(1)) begin
               run_d = 1'b0;
               exp_d = 1'b1;
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
      if (wr_tload) begin
         count_d = bus.dwdata;
         presc_d = '0;
         run_d   = (bus.dwdata != '0);
         exp_d   = (bus.dwdata == '0);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
         presc_q <= '0;
         run_q   <= 1'b0;
         exp_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         presc_q <= presc_d;
         run_q   <= run_d;
         exp_q   <= exp_d;
      end
   end

   always_comb begin
      tload_rd            = count_q;
      tstat_rd            = '0;
      tstat_rd[TSTAT_RUN] = run_q;
      tstat_rd[TSTAT_EXP] = exp_q;
   end
`else
   assign tload_rd = '0;
   assign tstat_rd = '0;
`endif

   always_comb begin
      rdata = '0;
      if (bus.dread && hit) begin
         case (ofs)
            OFS_SW:    rdata = {{(DATA_W-2){1'b0}}, sw_stable};
            OFS_EDGE:  rdata = {{(DATA_W-2){1'b0}}, edge_flags_q};
            OFS_TLOAD: rdata = tload_rd;
            OFS_TSTAT: rdata = tstat_rd;
            default:   rdata = '0;
         endcase
      end
   end

   assign bus.drdata = rdata;
   assign bus.hit    = hit;

endmodule

// File: doc/leglite_io_port.md
# leglite_io_port

Memory-mapped I/O responder for the LEGLite single-cycle CPU data bus, sitting beside data memory inside the DMemory/IO block. It answers CPU loads and stores to a small register window. The window provides:
- debounced sliding-switch inputs;
- W1C rising-edge flags for those switches;
- a programmable countdown timer.

Reads are combinational so that a single-cycle load completes in one cycle; all state updates on the rising clock edge.

## Interface
- BASE, 16'hFFF0: byte address of the register window; 8-byte aligned.
- DEB_CYCLES, 4: consecutive differing cycles required before a debounced switch changes; ≥2.
- PRESCALE, 1: clock cycles per timer decrement; ≥1.

- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- draddr  in  16  data address (ALU output)
- dwdata  in  16  store data
- dwrite  in  1  store enable
- dread  in  1  load enable
- drdata  out  16  load data; 0 when not hit
- hit  out  1  draddr[15:3]==BASE[15:3]; selects this block in the host read mux
- io_sw0, io_sw1  in  1  raw asynchronous switch inputs

## Operation
- Decode: draddr[2:1] selects the register; draddr[0] is ignored. Accesses with hit=0 have no effect.
- Register map:
  - +0 SW (RO): bit0 = debounced sw0, bit1 = debounced sw1, other bits 0.
  - +2 EDGE (W1C): bit0/1 set on a debounced 0→1 transition of sw0/sw1.
  - +4 TLOAD (RW): read returns the current count. Write loads count ← dwdata, resets the prescaler, sets running=1 and clears expired.
  - +6 TSTAT: bit0 running (RO), bit1 expired (W1C).
- Debounce (per switch):
  - Two-flop synchronizer feeds stage s2.
  - A counter runs while s2≠stable and is cleared when they are equal.
  - When the counter reaches DEB_CYCLES−1 with s2 still ≠ stable, stable ← s2 and the counter clears.
- Timer:
  - While running, the prescaler counts 0..PRESCALE−1.
  - On wrap, count decrements.
  - When count transitions 1→0: running←0 and expired←1.
  - Loading 0: running←0 and expired←1 on the write edge.
  - Count never wraps below 0.
- Reset values: SW=0, EDGE=0, count=0, prescaler=0, running=0, expired=0, synchronizer and debounce counters 0. drdata=0 and hit follow inputs combinationally.

## Timing
- drdata is combinational from draddr/dread, zero latency. drdata=0 if dread=0 or hit=0.
- Writes take effect at the rising edge where dwrite=1 and hit=1; a read in the same cycle returns pre-edge values.
- Switch latency: a clean input change is visible in SW exactly DEB_CYCLES+2 edges after it occurs. The EDGE bit sets on the same edge SW rises.
- Glitch rejection: any pulse shorter than DEB_CYCLES cycles at s2 is rejected.
- Simultaneous events:
  - A set event wins over a W1C clear in the same cycle, for both EDGE and expired.
  - A TLOAD write wins over a same-cycle expiry or decrement.
- Reset asserted mid-operation: all state returns to reset values on that edge. reset has priority over writes.
- With PRESCALE=1 and load N>0, expired sets N edges after the load edge.

## Configuration
- LEGLITE_IO_TIMER_EN:
  - Defined: the timer registers (+4, +6) exist as specified.
  - Undefined: no timer logic is built; +4 and +6 read 0 and writes to them are ignored, while hit still asserts for the whole window.
  - SW/EDGE behaviour is identical in both builds.

## Structure
- Package leglite_io_pkg holds:
  - register offset constants (OFS_SW=0, OFS_EDGE=2, OFS_TLOAD=4, OFS_TSTAT=6);
  - TSTAT bit indices (RUN=0, EXP=1);
  - the 16-bit data width constant.
- Sub-module sw_debounce, instantiated once per switch:
  - parameter DEB_CYCLES;
  - ports clock, reset, raw, stable, rise;
  - contains the synchronizer and the debounce counter.
- The top level holds the decode, the EDGE/TSTAT flags, the timer and the read mux.

## Test plan
- Reset with io_sw0=1 held → SW reads 0 at the reset release edge. SW reads 16'h0001 exactly DEB_CYCLES+2 edges after release (default 6). EDGE reads 16'h0001.
- Toggle io_sw1 high for 3 cycles then low, DEB_CYCLES=4 → SW bit1 stays 0 and EDGE bit1 stays 0.
- With EDGE=16'h0003, store 16'h0001 to BASE+2 → EDGE reads 16'h0002. Repeat the store on the same edge as a new sw0 rise → EDGE reads 16'h0003.
- Store 16'd3 to BASE+4 with PRESCALE=1 → TSTAT reads 16'h0001 for 3 cycles, then 16'h0002. TLOAD reads 3,2,1,0.
- Store 0 to BASE+4 → TSTAT reads 16'h0002 on the next cycle. Store 16'h0002 to BASE+6 → TSTAT reads 0. Assert reset while the timer runs from 16'd10 → count=0 and TSTAT=0 after the reset edge.
- Load/read at draddr=16'h0010 → hit=0, drdata=0, no register changes. Build without LEGLITE_IO_TIMER_EN: store 16'd5 to BASE+4 → BASE+4 and BASE+6 read 0.
